// File: rtl/dcache_pkg.sv
// Shared types and address-field widths for the direct-mapped write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  localparam int NUM_LINES_DEF  = 32;
  localparam int LINE_BYTES_DEF = 32;

  function automatic int off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int num_lines, input int line_bytes);
    return 32 - $clog2(num_lines) - $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: one combinational read port and one write port, both at idx.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = NUM_LINES_DEF,
  parameter int LINE_BYTES = LINE_BYTES_DEF
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [idx_w(NUM_LINES)-1:0]               idx,
  output logic                                      rd_valid,
  output logic                                      rd_dirty,
  output logic [tag_w(NUM_LINES, LINE_BYTES)-1:0]   rd_tag,
  output logic [8*LINE_BYTES-1:0]                   rd_line,
  input  logic                                      word_en,
  input  logic [off_w(LINE_BYTES)-3:0]              word_sel,
  input  logic [31:0]                               word_data,
  input  logic                                      fill_en,
  input  logic [tag_w(NUM_LINES, LINE_BYTES)-1:0]   fill_tag,
  input  logic [8*LINE_BYTES-1:0]                   fill_line,
  input  logic                                      clean_en
);

  localparam int TAG_W  = tag_w(NUM_LINES, LINE_BYTES);
  localparam int LINE_W = 8 * LINE_BYTES;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_en) begin
      dirty_q[idx] <= 1'b1;
    end else if (clean_en) begin
      dirty_q[idx] <= 1'b0;
    end
  end

  // Tag and data are intentionally left unreset; valid gates their use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_line;
    end else if (word_en) begin
      data_q[idx][32*int'(word_sel) +: 32] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller with whole-line memory port.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = NUM_LINES_DEF,
  parameter int LINE_BYTES = LINE_BYTES_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cpu_req_i,
  input  logic                    cpu_we_i,
  input  logic [31:0]             cpu_addr_i,
  input  logic [31:0]             cpu_wdata_i,
  output logic [31:0]             cpu_rdata_o,
  output logic                    cpu_stall_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [31:0]             mem_addr_o,
  output logic [8*LINE_BYTES-1:0] mem_wdata_o,
  input  logic [8*LINE_BYTES-1:0] mem_rdata_i,
  input  logic                    mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]             hit_cnt_o,
  output logic [31:0]             miss_cnt_o
`endif
);

  localparam int OFF_W  = off_w(LINE_BYTES);
  localparam int IDX_W  = idx_w(NUM_LINES);
  localparam int TAG_W  = tag_w(NUM_LINES, LINE_BYTES);
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int WSEL_W = OFF_W - 2;

  logic [TAG_W-1:0]  cpu_tag;
  logic [IDX_W-1:0]  idx;
  logic [WSEL_W-1:0] wsel;
  logic              unused_bits;

  assign cpu_tag     = cpu_addr_i[31 -: TAG_W];
  assign idx         = cpu_addr_i[OFF_W +: IDX_W];
  assign wsel        = cpu_addr_i[2 +: WSEL_W];
  assign unused_bits = ^cpu_addr_i[1:0];

  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              word_en, fill_en, clean_en;

  dcache_array #(
    .NUM_LINES (NUM_LINES),
    .LINE_BYTES(LINE_BYTES)
  ) u_array (
    .clk      (clk_i),
    .rst      (rst_i),
    .idx      (idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .word_en  (word_en),
    .word_sel (wsel),
    .word_data(cpu_wdata_i),
    .fill_en  (fill_en),
    .fill_tag (cpu_tag),
    .fill_line(mem_rdata_i),
    .clean_en (clean_en)
  );

  state_t state, state_nx;
  logic   hit, idle, accept;

  assign hit    = cpu_req_i & rd_valid & (rd_tag == cpu_tag);
  assign idle   = (state == IDLE);
  assign accept = idle & hit;

  assign cpu_stall_o = cpu_req_i & ~accept;
  assign cpu_rdata_o = accept ? rd_line[32*int'(wsel) +: 32] : 32'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (cpu_req_i && !hit) state_nx = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (mem_ack_i) state_nx = ALLOCATE;
      ALLOCATE:  if (mem_ack_i) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Array writes are suppressed during reset so an abandoned transaction leaves no trace.
  always_comb begin
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    word_en   = 1'b0;
    fill_en   = 1'b0;
    clean_en  = 1'b0;
    unique case (state)
      IDLE:      word_en = accept & cpu_we_i & ~rst_i;
      WRITEBACK: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        clean_en  = mem_ack_i & ~rst_i;
      end
      ALLOCATE:  begin
        mem_req_o = 1'b1;
        fill_en   = mem_ack_i & ~rst_i;
      end
      default:   ;
    endcase
  end

  logic [31:0]       addr_q;
  logic [LINE_W-1:0] wb_line_q;

  // Memory-side address and victim line are captured on entry to each phase and held.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else if (idle && state_nx == WRITEBACK) begin
      addr_q    <= {rd_tag, idx, {OFF_W{1'b0}}};
      wb_line_q <= rd_line;
    end else if (state != ALLOCATE && state_nx == ALLOCATE) begin
      addr_q <= {cpu_tag, idx, {OFF_W{1'b0}}};
    end
  end

  assign mem_addr_o  = mem_req_o ? addr_q : 32'd0;
  assign mem_wdata_o = (state == WRITEBACK) ? wb_line_q : '0;

`ifdef DCACHE_STATS_EN
  logic missed_q;

  // missed_q keeps the post-fill completion of a missed access out of the hit count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      missed_q   <= 1'b0;
    end else begin
      if (accept) begin
        if (!missed_q) hit_cnt_o <= hit_cnt_o + 32'd1;
        missed_q <= 1'b0;
      end
      if (idle && state_nx != IDLE) begin
        miss_cnt_o <= miss_cnt_o + 32'd1;
        missed_q   <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus randomized accesses
// checked against a line-level cache model and a backing-memory table.
module tb_dcache_ctrl;

  localparam int NL = 32;
  localparam int LW = 256;
  typedef logic [LW-1:0] val_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          mem_req, mem_we, mem_ack;
  logic [31:0]   mem_addr;
  logic [LW-1:0] mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0]   hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cpu_req_i  (cpu_req),
    .cpu_we_i   (cpu_we),
    .cpu_addr_i (cpu_addr),
    .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata),
    .cpu_stall_o(cpu_stall),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .mem_ack_i  (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input val_t got, input val_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: cache contents per line, plus backing memory keyed by line address.
  bit            m_valid [NL];
  bit            m_dirty [NL];
  logic [21:0]   m_tag   [NL];
  logic [LW-1:0] m_line  [NL];
  logic [LW-1:0] backing [logic [31:0]];
  int            m_hits, m_misses;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [LW-1:0] mem_line(input logic [31:0] la);
    if (!backing.exists(la)) backing[la] = rand_line();
    return backing[la];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  // One CPU access, acting as memory for any miss; k_fix>0 forces the ack latency.
  task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int k_fix);
    int          idx, w, stalls, exp_stalls, ph_cnt, ph_k, guard;
    logic [21:0] tg;
    bit          hit, in_wb, ph_new;
    logic [31:0] wb_addr, fill_addr;
    idx       = int'(addr[9:5]);
    w         = int'(addr[4:2]);
    tg        = addr[31:10];
    hit       = m_valid[idx] && (m_tag[idx] == tg);
    in_wb     = !hit && m_valid[idx] && m_dirty[idx];
    wb_addr   = {m_tag[idx], addr[9:5], 5'b0};
    fill_addr = {tg, addr[9:5], 5'b0};
    stalls = 0; ph_cnt = 0; ph_k = 0; guard = 0; ph_new = 1'b1;
    exp_stalls = hit ? 0 : 1;

    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; mem_ack = 1'b0;
    #1;
    while (cpu_stall && guard < 100) begin
      stalls++;
      guard++;
      if (mem_req) begin
        if (ph_new) begin
          ph_new = 1'b0;
          ph_cnt = 0;
          ph_k   = (k_fix > 0) ? k_fix : int'($urandom_range(1, 4));
          exp_stalls += ph_k;
          check_val("phase_we", val_t'(mem_we), val_t'(in_wb));
          if (in_wb) begin
            check_val("wb_addr", val_t'(mem_addr), val_t'(wb_addr));
            check_val("wb_data", mem_wdata, m_line[idx]);
          end else begin
            check_val("fill_addr", val_t'(mem_addr), val_t'(fill_addr));
            check_val("fill_wdata_zero", mem_wdata, '0);
          end
        end
        ph_cnt++;
        if (ph_cnt == ph_k) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            backing[wb_addr] = m_line[idx];
            in_wb = 1'b0;
          end else begin
            mem_rdata = mem_line(fill_addr);
          end
          ph_new = 1'b1;
        end
      end
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = rand_line();
      #1;
    end
    if (guard >= 100) check_val("timeout", val_t'(1), val_t'(0));
    check_val("stall_cycles", val_t'(stalls), val_t'(exp_stalls));

    if (!hit) begin
      check_val("req_drop", val_t'(mem_req), val_t'(0));
      m_line[idx]  = mem_line(fill_addr);
      m_tag[idx]   = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_misses++;
    end else begin
      m_hits++;
    end
    if (we) begin
      m_line[idx][w*32 +: 32] = wdata;
      m_dirty[idx] = 1'b1;
    end else begin
      check_val("load_data", val_t'(cpu_rdata), val_t'(m_line[idx][w*32 +: 32]));
    end
  endtask

  // No request: outputs must be quiet and a stray ack must be ignored.
  task automatic idle_cycle();
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'(($urandom));
    cpu_addr = $urandom; mem_ack = 1'($urandom);
    #1;
    check_val("idle_stall", val_t'(cpu_stall), val_t'(0));
    check_val("idle_rdata", val_t'(cpu_rdata), val_t'(0));
    check_val("idle_req", val_t'(mem_req), val_t'(0));
  endtask

  initial begin
    logic [LW-1:0] l;
    int            guard;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_req", val_t'(mem_req), val_t'(0));
    check_val("rst_we", val_t'(mem_we), val_t'(0));
    check_val("rst_addr", val_t'(mem_addr), val_t'(0));
    check_val("rst_stall", val_t'(cpu_stall), val_t'(0));

    l = rand_line();
    l[31:0]  = 32'hDEADBEEF;
    l[63:32] = 32'hC0FFEE01;
    backing[32'h40] = l;
    do_access(1'b0, 32'h40, 32'h0, 3);
    check_val("cold_word0", val_t'(cpu_rdata), val_t'(32'hDEADBEEF));
    do_access(1'b0, 32'h44, 32'h0, 0);
    check_val("hit_word1", val_t'(cpu_rdata), val_t'(32'hC0FFEE01));
    do_access(1'b1, 32'h40, 32'h12345678, 0);
    do_access(1'b0, 32'h40, 32'h0, 0);
    check_val("store_readback", val_t'(cpu_rdata), val_t'(32'h12345678));
    do_access(1'b0, 32'h440, 32'h0, 2);
    check_val("wb_backing_word0", val_t'(backing[32'h40][31:0]), val_t'(32'h12345678));
    do_access(1'b1, 32'h80, 32'hA5A55A5A, 0);
    do_access(1'b0, 32'h80, 32'h0, 0);
    do_access(1'b0, 32'h84, 32'h0, 0);
    idle_cycle();

    // Reset while a writeback is outstanding.
    do_access(1'b1, 32'h440, 32'h0BADF00D, 0);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; mem_ack = 1'b0;
    #1;
    guard = 0;
    while (!(mem_req && mem_we) && guard < 10) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check_val("wb_reached", val_t'(mem_req && mem_we), val_t'(1));
    check_val("wb_abort_addr", val_t'(mem_addr), val_t'(32'h440));
    cpu_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("abort_req", val_t'(mem_req), val_t'(0));
    check_val("abort_we", val_t'(mem_we), val_t'(0));
    check_val("abort_addr", val_t'(mem_addr), val_t'(0));
    model_reset();
    do_access(1'b0, 32'h440, 32'h0, 0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = {20'($urandom_range(0, 3)), 2'b0, 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b0};
      if ($urandom_range(0, 3) == 0) idle_cycle();
      do_access(1'($urandom), a, $urandom, 0);
    end
    idle_cycle();

`ifdef DCACHE_STATS_EN
    check_val("hit_cnt", val_t'(hit_cnt), val_t'(m_hits));
    check_val("miss_cnt", val_t'(miss_cnt), val_t'(m_misses));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate L1 data cache controller. It sits directly downstream of the pipeline MEM stage and replaces the direct Data_Memory connection.
- CPU side: consumes the EXMEM ALU address, store data and MemRead/MemWrite.
- CPU side: returns load data to MEMWB, plus a stall used to freeze the whole pipeline.
- Memory side: a whole-line req/ack interface to off-chip data memory.

Parameters:
- NUM_LINES, 32, number of cache lines; power of 2; index width IDX_W = log2(NUM_LINES).
- LINE_BYTES, 32, bytes per line; power of 2, >= 4; offset width OFF_W = log2(LINE_BYTES); line width LINE_W = 8*LINE_BYTES.
- Tag width is 32-IDX_W-OFF_W (22 at defaults).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. Synchronous, active-high.
- cpu_req_i  in  1  access request (MemRead|MemWrite from EXMEM).
- cpu_we_i  in  1  1=store, 0=load.
- cpu_addr_i  in  32  byte address; word-aligned.
- cpu_wdata_i  in  32  store data.
- cpu_rdata_o  out  32  load data; valid when cpu_req_i=1 and cpu_stall_o=0.
- cpu_stall_o  out  1  freeze pipeline.
- mem_req_o  out  1  memory request, held until ack.
- mem_we_o  out  1  1=line writeback, 0=line fill.
- mem_addr_o  out  32  line-aligned address (low OFF_W bits zero).
- mem_wdata_o  out  LINE_W  evicted line.
- mem_rdata_i  in  LINE_W  fill data; valid with ack.
- mem_ack_i  in  1  one-cycle completion pulse.

Behaviour:
- Address split: offset [OFF_W-1:0]; word select [OFF_W-1:2]; index [OFF_W+IDX_W-1:OFF_W]; tag is the remaining upper bits.
- Per-line storage: valid bit, dirty bit, tag, LINE_W data.
- Lookup is combinational: hit = cpu_req_i & valid[idx] & (tag[idx]==addr tag).
- Load hit: cpu_rdata_o returns the selected word in the same cycle; cpu_stall_o=0.
- Store hit: word merged at the clock edge; dirty set; cpu_stall_o=0.
- cpu_stall_o = cpu_req_i & (state!=IDLE | !hit). It is 0 whenever cpu_req_i=0.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, miss, victim dirty -> WRITEBACK. Victim = valid & dirty.
- IDLE, miss, victim clean or invalid -> ALLOCATE.
- WRITEBACK:
  - mem_req_o=1, mem_we_o=1.
  - mem_addr_o = {victim tag, idx, 0}; mem_wdata_o = victim line.
  - On mem_ack_i: dirty cleared, go to ALLOCATE.
- ALLOCATE:
  - mem_req_o=1, mem_we_o=0, mem_addr_o = {cpu tag, idx, 0}.
  - On mem_ack_i: line := mem_rdata_i, tag written, valid=1, dirty=0, go to IDLE.
- After ALLOCATE, IDLE re-evaluates the lookup, which now hits. A store miss is completed by that hit (write-allocate; dirty set).
- Latency: clean miss stalls 1+k cycles, where ack arrives in the k-th cycle of ALLOCATE (k>=1). A dirty miss adds the WRITEBACK cycle count.
- Memory handshake:
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o come from state and registers, glitch-free.
  - They are stable from req rise until the ack cycle.
  - mem_req_o drops in the cycle after the ack edge if no further request follows.
  - mem_ack_i while mem_req_o=0 is ignored.
- CPU contract: cpu_addr_i, cpu_we_i and cpu_wdata_i are held stable while cpu_stall_o=1. The controller re-samples them every cycle.
- Outputs when not active:
  - mem_wdata_o = 0 when not in WRITEBACK.
  - cpu_rdata_o = 0 when cpu_req_i=0 or the access is a miss.
- Reset (rst_i=1 at an edge):
  - state = IDLE; all valid and dirty bits = 0. Tag and data arrays are not cleared.
  - mem_req_o = 0 the following cycle; mem_we_o = 0; mem_addr_o = 0.
- Reset mid-WRITEBACK or mid-ALLOCATE: the transaction is abandoned and no array update occurs. The memory model must accept a dropped request.

Optional Feature:
DCACHE_STATS_EN
- Defined:
  - Adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - hit_cnt_o increments once per access completed without any miss. Count each access once, at the accepting edge where cpu_stall_o=0.
  - miss_cnt_o increments once per IDLE->WRITEBACK or IDLE->ALLOCATE transition.
  - Both counters wrap at 2^32 and clear on rst_i.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package dcache_pkg:
  - FSM state enum (IDLE, WRITEBACK, ALLOCATE).
  - Default NUM_LINES and LINE_BYTES.
  - Field-width localparam functions (OFF_W, IDX_W, TAG_W).
- Sub-module dcache_array: tag/valid/dirty/data storage.
  - One combinational read port at the index.
  - One synchronous write port with word-merge enable and fill enable.
  - Bulk valid/dirty clear on reset.

Test Plan:
- Cold load 0x0000_0040 after reset; ack at k=3 with fill word0=0xDEADBEEF -> stall high exactly 4 cycles; mem_addr_o=0x40, mem_we_o=0; then cpu_rdata_o=0xDEADBEEF with stall 0.
- Load 0x0000_0044 after that fill -> same-cycle hit, no mem_req_o; returns fill word1.
- Store 0x12345678 to 0x40 (hit) -> stall 0, dirty set; a later load of 0x40 returns 0x12345678.
- Load 0x0000_0440 (same index 2, tag 1) with the line dirty -> WRITEBACK (mem_addr_o=0x40, mem_we_o=1, mem_wdata_o word0=0x12345678), then ALLOCATE at 0x440, then hit.
- Store miss to 0x0000_0080 -> fill, then merge; line dirty; the word reads back the stored value, other words keep their fill data.
- rst_i pulsed during WRITEBACK with ack not yet given -> mem_req_o=0 next cycle, state IDLE; a subsequent load to 0x440 misses.
